// File: rtl/adc_conv_responder.sv
// ADC emulator answering the adc_start / adc_ready / adc_value handshake with per-channel ramps.
// Optional build macro: ADC_EMU_NOISE_EN (adds LFSR dither on adc_value[1:0]).
module adc_conv_responder #(
  parameter int          SAMPLE_CYCLES = 4,
  parameter int          CONV_CYCLES   = 32,
  parameter logic [13:0] STEP          = 14'd16,
  parameter logic [13:0] CH_OFFSET     = 14'd1024,
  parameter int          NUM_CH        = 8
) (
  input  logic        adc_clk,
  input  logic        rst_n,
  input  logic        adc_start,
  input  logic [2:0]  adc_channel_ind,
  output logic        adc_ready,
  output logic [13:0] adc_value,
  output logic        adc_busy,
  output logic [3:0]  adc_counts,
  output logic        adc_overrun
);

  // Handshake: adc_start is a level sampled every cycle and is only accepted in
  // IDLE or DONE; adc_ready is a single-cycle pulse in DONE with adc_value valid
  // in that same cycle. Starts seen while busy are dropped and flagged sticky.
  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  localparam logic [7:0] SAMPLE_LOAD = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0] CONV_LOAD   = 8'(CONV_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic [2:0]  ch;
  logic        accept;
  logic        enter_done;
  logic [13:0] ramp [NUM_CH];
  logic [13:0] result;
  logic [13:0] result_out;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (adc_start) begin
          accept    = 1'b1;
          state_nxt = SAMPLE;
          cnt_nxt   = SAMPLE_LOAD;
        end
      end
      SAMPLE: begin
        if (cnt == 8'd0) begin
          state_nxt = CONVERT;
          cnt_nxt   = CONV_LOAD;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      CONVERT: begin
        if (cnt == 8'd0) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      DONE: begin
        if (adc_start) begin
          accept    = 1'b1;
          state_nxt = SAMPLE;
          cnt_nxt   = SAMPLE_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channels beyond NUM_CH have no ramp and report full scale.
  always_comb begin
    result = 14'h3FFF;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch == 3'(i)) result = ramp[i] + 14'(i) * CH_OFFSET;
    end
  end

`ifdef ADC_EMU_NOISE_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; only the reported value is dithered.
  always_ff @(posedge adc_clk) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign result_out = {result[13:2], result[1:0] ^ lfsr[1:0]};
`else
  assign result_out = result;
`endif

  assign adc_ready = (state == DONE);
  assign adc_busy  = (state == SAMPLE) || (state == CONVERT);

  always_ff @(posedge adc_clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      ch          <= 3'd0;
      adc_value   <= 14'd0;
      adc_counts  <= 4'd0;
      adc_overrun <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) ramp[i] <= 14'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) ch <= adc_channel_ind;
      if (enter_done) begin
        adc_value  <= result_out;
        adc_counts <= adc_counts + 4'd1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch == 3'(i)) ramp[i] <= ramp[i] + STEP;
        end
      end
      if (adc_start && adc_busy) adc_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_conv_responder.sv
// Self-checking bench for adc_conv_responder: directed steps plus randomized
// channels, checked against an arithmetic ramp model.
module tb_adc_conv_responder;

  logic        adc_clk = 1'b0;
  logic        rst_n;
  logic        adc_start;
  logic [2:0]  adc_channel_ind;
  logic        adc_ready;
  logic [13:0] adc_value;
  logic        adc_busy;
  logic [3:0]  adc_counts;
  logic        adc_overrun;

  logic        start2;
  logic [2:0]  chan2;
  logic        ready2;
  logic [13:0] value2;
  logic        busy2;
  logic [3:0]  counts2;
  logic        overrun2;

  int tests  = 0;
  int failed = 0;

  int          ramp_m [8];
  int          counts_m;
  logic [13:0] val_mask;

  always #5 adc_clk = ~adc_clk;

  adc_conv_responder dut (
    .adc_clk(adc_clk), .rst_n(rst_n), .adc_start(adc_start),
    .adc_channel_ind(adc_channel_ind), .adc_ready(adc_ready),
    .adc_value(adc_value), .adc_busy(adc_busy), .adc_counts(adc_counts),
    .adc_overrun(adc_overrun)
  );

  // Narrow instance: 4 channels and minimum phase lengths.
  adc_conv_responder #(.SAMPLE_CYCLES(1), .CONV_CYCLES(1), .NUM_CH(4)) dut2 (
    .adc_clk(adc_clk), .rst_n(rst_n), .adc_start(start2),
    .adc_channel_ind(chan2), .adc_ready(ready2), .adc_value(value2),
    .adc_busy(busy2), .adc_counts(counts2), .adc_overrun(overrun2)
  );

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ramp_m[i] = 0;
    counts_m = 0;
  endtask

  // One completed conversion on channel c of an 8-channel, step-16, offset-1024 ADC.
  task automatic model_step(input int c, input int num_ch, output logic [13:0] v);
    if (c < num_ch) begin
      v = 14'((ramp_m[c] + c * 1024) % 16384);
      ramp_m[c] = (ramp_m[c] + 16) % 16384;
    end else begin
      v = 14'h3FFF;
    end
    counts_m = (counts_m + 1) % 16;
  endtask

  task automatic do_conv(input logic [2:0] c, input int pulse_at, input string tag);
    int          lat;
    int          busy_bad;
    logic [13:0] exp_v;
    adc_start = 1'b1;
    adc_channel_ind = c;
    tick();
    adc_start = 1'b0;
    adc_channel_ind = 3'($urandom_range(0, 7));
    lat = 0;
    busy_bad = 0;
    for (int n = 1; n <= 60; n++) begin
      if (adc_ready) begin
        lat = n;
        break;
      end
      if (!adc_busy) busy_bad++;
      adc_start = (n == pulse_at);
      if (adc_start) adc_channel_ind = 3'($urandom_range(0, 7));
      tick();
    end
    adc_start = 1'b0;
    model_step(int'(c), 8, exp_v);
    check({tag, " latency"}, 32'(lat), 32'd37);
    check({tag, " busy span"}, 32'(busy_bad), 32'd0);
    check({tag, " busy in done"}, 32'(adc_busy), 32'd0);
    check({tag, " value"}, 32'(adc_value & val_mask), 32'(exp_v & val_mask));
    check({tag, " counts"}, 32'(adc_counts), 32'(counts_m));
    tick();
    check({tag, " ready one cycle"}, 32'(adc_ready), 32'd0);
    check({tag, " value held"}, 32'(adc_value & val_mask), 32'(exp_v & val_mask));
  endtask

  task automatic do_conv2(input logic [2:0] c, input logic [13:0] exp_v, input string tag);
    int lat;
    start2 = 1'b1;
    chan2 = c;
    tick();
    start2 = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      if (ready2) begin
        lat = n;
        break;
      end
      tick();
    end
    check({tag, " latency"}, 32'(lat), 32'd3);
    check({tag, " value"}, 32'(value2 & val_mask), 32'(exp_v & val_mask));
    tick();
  endtask

  initial begin
    int          n1;
    int          n2;
    int          nready;
    int          gap;
    logic [13:0] ev;

`ifdef ADC_EMU_NOISE_EN
    val_mask = 14'h3FFC;
`else
    val_mask = 14'h3FFF;
`endif
    rst_n = 1'b0;
    adc_start = 1'b0;
    adc_channel_ind = 3'd0;
    start2 = 1'b0;
    chan2 = 3'd0;
    model_reset();

    // Reset state
    repeat (3) tick();
    check("reset ready", 32'(adc_ready), 32'd0);
    check("reset value", 32'(adc_value), 32'd0);
    check("reset busy", 32'(adc_busy), 32'd0);
    check("reset counts", 32'(adc_counts), 32'd0);
    check("reset overrun", 32'(adc_overrun), 32'd0);
    rst_n = 1'b1;
    tick();

    // First conversions and channel offsets
    do_conv(3'd0, 0, "ch0 first");
    check("ch0 first const", 32'(adc_value & val_mask), 32'd0);
    check("ch0 first counts", 32'(adc_counts), 32'd1);
    do_conv(3'd0, 0, "ch0 second");
    check("ch0 second const", 32'(adc_value & val_mask), 32'(14'd16 & val_mask));
    do_conv(3'd3, 0, "ch3 first");
    check("ch3 first const", 32'(adc_value & val_mask), 32'(14'd3072 & val_mask));
    do_conv(3'd0, 0, "ch0 third");
    check("ch0 third const", 32'(adc_value & val_mask), 32'(14'd32 & val_mask));
    check("overrun clear", 32'(adc_overrun), 32'd0);

    // Start during an active conversion
    do_conv(3'd2, 10, "overrun conv");
    check("overrun set", 32'(adc_overrun), 32'd1);

    // Back-to-back conversions with start held through DONE
    adc_start = 1'b1;
    adc_channel_ind = 3'd1;
    tick();
    n1 = 0; n2 = 0; nready = 0; gap = 0;
    for (int n = 1; n <= 90; n++) begin
      if (adc_ready) begin
        nready++;
        model_step(1, 8, ev);
        check("b2b value", 32'(adc_value & val_mask), 32'(ev & val_mask));
        check("b2b counts", 32'(adc_counts), 32'(counts_m));
        if (n1 == 0) n1 = n;
        else if (n2 == 0) n2 = n;
      end else if (n < 74 && !adc_busy) begin
        gap++;
      end
      adc_start = (n < 74);
      tick();
    end
    adc_start = 1'b0;
    check("b2b ready count", 32'(nready), 32'd2);
    check("b2b first at", 32'(n1), 32'd37);
    check("b2b second at", 32'(n2), 32'd74);
    check("b2b idle gap", 32'(gap), 32'd0);
    check("overrun sticky", 32'(adc_overrun), 32'd1);

    // Randomized channels, some with stray starts
    for (int k = 0; k < 24; k++) begin
      do_conv(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 36)) : 0,
              "random");
    end
    check("overrun still set", 32'(adc_overrun), 32'd1);

    // Reset mid-CONVERT, with a start on the reset edge
    adc_start = 1'b1;
    adc_channel_ind = 3'd0;
    tick();
    adc_start = 1'b0;
    repeat (19) tick();
    check("pre-reset busy", 32'(adc_busy), 32'd1);
    rst_n = 1'b0;
    adc_start = 1'b1;
    tick();
    check("midrst ready", 32'(adc_ready), 32'd0);
    check("midrst value", 32'(adc_value), 32'd0);
    check("midrst busy", 32'(adc_busy), 32'd0);
    check("midrst counts", 32'(adc_counts), 32'd0);
    check("midrst overrun", 32'(adc_overrun), 32'd0);
    rst_n = 1'b1;
    adc_start = 1'b0;
    model_reset();
    tick();
    check("start dropped busy", 32'(adc_busy), 32'd0);
    nready = 0;
    for (int n = 0; n < 45; n++) begin
      if (adc_ready) nready++;
      tick();
    end
    check("midrst no ready", 32'(nready), 32'd0);

    // Ramp wrap over 1025 ch0 conversions
    do_conv(3'd0, 0, "post-reset ch0");
    check("post-reset ch0 const", 32'(adc_value & val_mask), 32'd0);
    for (int k = 0; k < 1023; k++) do_conv(3'd0, 0, "wrap run");
    do_conv(3'd0, 0, "wrap last");
    check("wrap value", 32'(adc_value & val_mask), 32'd0);
    check("wrap counts", 32'(adc_counts), 32'd1);

    // Out-of-range channels on the 4-channel instance
    do_conv2(3'd5, 14'h3FFF, "n4 ch5");
    do_conv2(3'd1, 14'd1024, "n4 ch1");
    do_conv2(3'd5, 14'h3FFF, "n4 ch5 again");
    do_conv2(3'd1, 14'd1040, "n4 ch1 again");
    do_conv2(3'd3, 14'd3072, "n4 ch3");
    check("n4 counts", 32'(counts2), 32'd5);
    check("n4 busy idle", 32'(busy2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/adc_conv_responder.md
Name:
adc_conv_responder

Overview:
Synthesizable ADC emulator. It is the responder end of the adc_start / adc_ready / adc_value conversion handshake. It replaces the hard ADC during bring-up and regression, so the conversion sequencer and its current_0/current_1 capture path can be exercised with deterministic, per-channel sample values. It sits on adc_clk, directly behind the sequencer's adc_start and adc_channel_ind outputs.

Parameters:
SAMPLE_CYCLES, 4, cycles spent in the SAMPLE phase (range 1 to 255)
CONV_CYCLES, 32, cycles spent in the CONVERT phase (range 1 to 255)
STEP, 14'd16, ramp increment applied per completed conversion on a channel
CH_OFFSET, 14'd1024, per-channel value offset; channel c adds c*CH_OFFSET
NUM_CH, 8, number of emulated channels (range 1 to 8)

Ports:
adc_clk  in  1  sole clock; all logic on the rising edge
rst_n  in  1  synchronous reset, active-low
adc_start  in  1  conversion request, level-sampled each cycle
adc_channel_ind  in  3  channel select, latched when a start is accepted
adc_ready  out  1  one-cycle pulse; adc_value is valid in that cycle
adc_value  out  14  conversion result, held until the next completion
adc_busy  out  1  high in SAMPLE and CONVERT
adc_counts  out  4  completed-conversion counter, wraps 15 to 0
adc_overrun  out  1  sticky flag: adc_start seen while busy

Behaviour:
- Reset: single clock, synchronous active-low rst_n.
  - While rst_n=0 at a clock edge: state goes to IDLE.
  - adc_ready=0, adc_value=0, adc_busy=0, adc_counts=0, adc_overrun=0.
  - All ramp registers clear to 0; the phase counter clears to 0.
  - Reset mid-conversion aborts it. No adc_ready pulse is produced, and no ramp or count update occurs.
- States: IDLE, SAMPLE, CONVERT, DONE.
- IDLE: adc_start=1 -> latch ch=adc_channel_ind, load counter=SAMPLE_CYCLES-1, go to SAMPLE.
- SAMPLE: counter decrements each cycle. At 0 -> load CONV_CYCLES-1, go to CONVERT.
- CONVERT: counter decrements each cycle. At 0 -> go to DONE and register the result.
- DONE: adc_ready=1 for exactly this cycle.
  - adc_start=1 in DONE: accepted as a new back-to-back request (latch channel, go to SAMPLE).
  - Otherwise: go to IDLE.
- Latency: if a start is accepted in cycle T, adc_ready is high in cycle T+SAMPLE_CYCLES+CONV_CYCLES+1. Defaults give T+37.
- adc_busy=1 exactly while in SAMPLE or CONVERT.
- Result for ch < NUM_CH:
  - adc_value = (ramp[ch] + ch*CH_OFFSET) mod 2^14, using the pre-increment ramp value.
  - Same edge: ramp[ch] <= (ramp[ch]+STEP) mod 2^14.
  - Other channels' ramps are untouched.
- Result for ch >= NUM_CH: adc_value=14'h3FFF, no ramp changes. adc_ready and adc_counts still behave normally.
- adc_counts increments on entry to DONE; 15 wraps to 0.
- adc_value changes only on entry to DONE (or on reset); it holds between completions.
- adc_start=1 in SAMPLE or CONVERT:
  - The request is ignored; the in-flight channel and timing are unchanged.
  - adc_overrun sets to 1 and stays set until reset.
- adc_channel_ind changes during a conversion have no effect.
- Reset and adc_start in the same cycle: reset wins, the start is dropped.

Optional Feature:
ADC_EMU_NOISE_EN
- Defined:
  - Adds a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, advancing every cycle.
  - On entry to DONE: adc_value[1:0] = computed_value[1:0] XOR lfsr[1:0]; bits [13:2] are unchanged.
  - Ramp registers stay noise-free.
- Undefined: no LFSR is built; adc_value is exactly the deterministic result.

Test Plan:
(defaults, macro undefined)
1. Release reset; start ch0 in cycle T -> adc_busy=1 from T+1 to T+36; adc_ready pulse only at T+37; adc_value=0; adc_counts=1.
2. Second ch0 conversion -> adc_value=16. Then first ch3 conversion -> adc_value=3072 (ch0 ramp stays 32).
3. Pulse adc_start at T+10 of an active conversion -> exactly one adc_ready at T+37; adc_overrun=1 and stays 1 afterwards.
4. Hold adc_start high through DONE -> back-to-back conversions with adc_ready at T+37 and T+74; no IDLE cycle between them.
5. Run 1024 ch0 conversions -> the 1025th returns adc_value=0 (ramp wrap); adc_counts=1 after 1025 completions (wrap).
6. Assert rst_n=0 at T+20 mid-CONVERT -> no adc_ready; all outputs 0; next ch0 conversion returns adc_value=0. With ADC_EMU_NOISE_EN defined, bits [13:2] match the expected values.
